muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL provide: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL provide: rst  input  1  synchronous, active-high reset.
REQ-003 The block SHALL provide: exe_cmd  input  EXE_CMD_LEN  execute command from the ID/EX stage.
REQ-004 The block SHALL provide: cmd_valid  input  1  exe_cmd and operands valid this cycle.
REQ-005 The block SHALL provide: val1, val2  input  32 each  operands; val1 is the multiplicand/dividend, val2 the multiplier/divisor.
REQ-006 The block SHALL provide: flush  input  1  aborts any in-flight operation.
REQ-007 The block SHALL provide: stall  output  1  hold request to the hazard/stall logic.
REQ-008 The block SHALL provide: result  output  32  write-back value.
REQ-009 The block SHALL provide: result_valid  output  1  one-cycle pulse qualifying result.
REQ-010 The block SHALL provide: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-011 Accepted commands SHALL be EXE_MULT, EXE_DIVHI, EXE_DIVLO, EXE_MFHI and EXE_MFLO; any other exe_cmd SHALL be ignored.
REQ-012 A command SHALL be accepted only when cmd_valid=1 and state=IDLE.
REQ-013 States SHALL be IDLE, MUL, DIV and DONE.
REQ-014 On acceptance, EXE_MULT SHALL go IDLE->MUL; EXE_DIVHI and EXE_DIVLO SHALL go IDLE->DIV.
REQ-015 MUL and DIV SHALL each run exactly 32 iterations with a 5-bit counter, then go to DONE; DONE SHALL go to IDLE after one cycle.
REQ-016 MUL SHALL be unsigned shift-add; at DONE, {hi,lo} SHALL equal the 64-bit product and result SHALL equal lo.
REQ-017 DIV SHALL be unsigned restoring division; at DONE, lo SHALL equal the quotient and hi SHALL equal the remainder.
REQ-018 For EXE_DIVLO, result SHALL equal the quotient; for EXE_DIVHI, result SHALL equal the remainder.
REQ-019 Divide by zero (val2=0) SHALL skip iteration and go IDLE->DONE; it SHALL give quotient 32'hFFFFFFFF and remainder val1.
REQ-020 Operands SHALL be latched at acceptance; later changes to val1/val2 SHALL have no effect.
REQ-021 EXE_MFHI and EXE_MFLO in IDLE SHALL drive result=hi or result=lo, with result_valid=1, in the same cycle; no state change SHALL occur.
REQ-022 result_valid SHALL be 1 for exactly the single DONE cycle of MUL/DIV operations; otherwise it SHALL be 0, except as in REQ-021.
REQ-023 stall SHALL be 1 when state is MUL or DIV.
REQ-024 stall SHALL be 1 in IDLE when a MULT/DIVHI/DIVLO command is presented.
REQ-025 stall SHALL be 0 in DONE and 0 for MFHI/MFLO.
REQ-026 Total latency from acceptance to result_valid SHALL be 33 cycles, or 1 cycle for divide by zero.
REQ-027 A command presented while the state is not IDLE SHALL be ignored; the upstream stall holds it until IDLE.
REQ-028 flush SHALL force IDLE on the next edge, leave hi/lo unchanged and suppress result_valid.
REQ-029 flush SHALL take priority over acceptance in the same cycle.
REQ-030 hi/lo SHALL change only in DONE.
REQ-031 A back-to-back command presented in the DONE cycle SHALL be accepted on the following IDLE cycle.

Reset
REQ-032 When rst=1 at a clock edge, the state SHALL go to IDLE and the counter, hi, lo and internal operand registers SHALL be cleared to 0.
REQ-033 During reset, result_valid and stall SHALL be 0; reset mid-operation SHALL discard the operation without writing hi/lo.

Structure
REQ-034 The EXE_* command encodings and EXE_CMD_LEN SHALL come from the shared defines file; no local copies SHALL exist.
REQ-035 The state encoding and iteration-count constant (32) SHALL be local parameters of this module.
REQ-036 The restoring-divide step SHALL be one combinational sub-module, div_step (32-bit trial subtract giving the next remainder and quotient bit).

Verification
REQ-037 Scenario 1: MULT 7 x 6 -> stall high for 33 cycles, then result_valid with result=42, hi=0, lo=42.
REQ-038 Scenario 2: MULT 32'hFFFFFFFF x 2 -> hi=1, lo=32'hFFFFFFFE.
REQ-039 Scenario 3: DIVLO 100/7 -> result=14, hi=2; then MFHI -> result=2 with result_valid in the same cycle.
REQ-040 Scenario 4: DIVHI 5/0 -> result_valid on the next cycle, result=5, lo=32'hFFFFFFFF.
REQ-041 Scenario 5: start MULT 3x3, flush at iteration 10 -> IDLE, no result_valid, hi/lo unchanged; MULT issued while busy is ignored.
REQ-042 Scenario 6: rst asserted mid-DIV -> all outputs 0 next cycle; a new DIVLO 9/3 then returns 3.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared execute-stage definitions for the multiply/divide unit.
// Holds the EXE_* command encodings and their width, plus a helper that
// tells the multi-cycle commands (MULT/DIVHI/DIVLO) apart from everything else.
package muldiv_unit_pkg;

    localparam int EXE_CMD_LEN = 4;

    typedef logic [EXE_CMD_LEN-1:0] exe_cmd_t;

    localparam exe_cmd_t EXE_NOP   = 4'd0;
    localparam exe_cmd_t EXE_MULT  = 4'd1;
    localparam exe_cmd_t EXE_DIVHI = 4'd2;
    localparam exe_cmd_t EXE_DIVLO = 4'd3;
    localparam exe_cmd_t EXE_MFHI  = 4'd4;
    localparam exe_cmd_t EXE_MFLO  = 4'd5;
    localparam exe_cmd_t EXE_ADD   = 4'd6;
    localparam exe_cmd_t EXE_SUB   = 4'd7;

    // True for the commands that occupy the unit for several cycles.
    function automatic logic is_long_op(input exe_cmd_t cmd);
        return (cmd == EXE_MULT) || (cmd == EXE_DIVHI) || (cmd == EXE_DIVLO);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Bundle between the ID/EX stage and the multiply/divide unit.
//   master (pipeline side): drives exe_cmd, cmd_valid, val1, val2, flush;
//                           receives stall, result, result_valid, hi, lo.
//   slave  (muldiv_unit)  : the reverse.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    exe_cmd_t    exe_cmd;
    logic        cmd_valid;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output exe_cmd, cmd_valid, val1, val2, flush,
        input  stall, result, result_valid, hi, lo
    );

    modport slave (
        input  exe_cmd, cmd_valid, val1, val2, flush,
        output stall, result, result_valid, hi, lo
    );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// One step of unsigned restoring division (purely combinational).
// Ports:
//   rem_in       partial remainder before this step (always < divisor)
//   dividend_bit next dividend bit shifted into the remainder
//   divisor      32-bit divisor
//   rem_out      partial remainder after the trial subtract
//   quot_bit     quotient bit produced by this step
module div_step (
    input  logic [31:0] rem_in,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        quot_bit
);
    logic [32:0] shifted;
    logic [33:0] diff;

    // The shifted remainder needs 33 bits; a 34-bit difference exposes the borrow.
    assign shifted  = {rem_in, dividend_bit};
    assign diff     = {1'b0, shifted} - {2'b00, divisor};
    assign quot_bit = ~diff[33];
    // On success the difference is below the divisor, so 32 bits suffice;
    // on failure the shifted value was below the divisor and also fits.
    assign rem_out  = quot_bit ? diff[31:0] : shifted[31:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with architectural HI/LO registers.
// MULT is a 32-step shift-add, DIVHI/DIVLO a 32-step restoring divide;
// MFHI/MFLO read HI/LO in the same cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  muldiv_unit_if.slave: command/operands/flush in; stall, result,
//        result_valid, hi, lo out
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         ITERATIONS = 32;
    localparam logic [4:0] LAST_ITER  = 5'(ITERATIONS - 1);

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    exe_cmd_t    cmd_reg, cmd_next;
    // opnd holds the multiplicand or the divisor.
    logic [31:0] opnd_reg, opnd_next;
    // MUL: {work_hi, work_lo} is the running product with the multiplier in the low half.
    // DIV: work_hi is the partial remainder, work_lo shifts dividend out / quotient in.
    logic [31:0] work_hi_reg, work_hi_next;
    logic [31:0] work_lo_reg, work_lo_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    logic [32:0] mul_sum;
    logic [31:0] step_rem;
    logic        step_bit;
    logic        long_cmd;

    logic        stall_now;
    logic        valid_now;
    logic [31:0] result_now;
    logic [31:0] hi_view;
    logic [31:0] lo_view;

    div_step u_div_step (
        .rem_in       (work_hi_reg),
        .dividend_bit (work_lo_reg[31]),
        .divisor      (opnd_reg),
        .rem_out      (step_rem),
        .quot_bit     (step_bit)
    );

    assign mul_sum  = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign long_cmd = bus.cmd_valid && is_long_op(bus.exe_cmd);

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        cmd_next     = cmd_reg;
        opnd_next    = opnd_reg;
        work_hi_next = work_hi_reg;
        work_lo_next = work_lo_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        stall_now    = 1'b0;
        valid_now    = 1'b0;
        result_now   = 32'd0;
        hi_view      = hi_reg;
        lo_view      = lo_reg;

        case (state_reg)
            IDLE: begin
                if (long_cmd) begin
                    stall_now = 1'b1;
                    if (!bus.flush) begin
                        cmd_next   = bus.exe_cmd;
                        count_next = 5'd0;
                        if (bus.exe_cmd == EXE_MULT) begin
                            opnd_next    = bus.val1;
                            work_hi_next = 32'd0;
                            work_lo_next = bus.val2;
                            state_next   = MUL;
                        end else if (bus.val2 == 32'd0) begin
                            // Divide by zero: results are known immediately.
                            opnd_next    = 32'd0;
                            work_hi_next = bus.val1;
                            work_lo_next = 32'hFFFF_FFFF;
                            state_next   = DONE;
                        end else begin
                            opnd_next    = bus.val2;
                            work_hi_next = 32'd0;
                            work_lo_next = bus.val1;
                            state_next   = DIV;
                        end
                    end
                end else if (bus.cmd_valid && !bus.flush) begin
                    if (bus.exe_cmd == EXE_MFHI) begin
                        valid_now  = 1'b1;
                        result_now = hi_reg;
                    end else if (bus.exe_cmd == EXE_MFLO) begin
                        valid_now  = 1'b1;
                        result_now = lo_reg;
                    end
                end
            end
            MUL: begin
                stall_now    = 1'b1;
                work_hi_next = mul_sum[32:1];
                work_lo_next = {mul_sum[0], work_lo_reg[31:1]};
                count_next   = count_reg + 5'd1;
                if (count_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DIV: begin
                stall_now    = 1'b1;
                work_hi_next = step_rem;
                work_lo_next = {work_lo_reg[30:0], step_bit};
                count_next   = count_reg + 5'd1;
                if (count_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // HI/LO show the new values during DONE and commit on its exit edge,
                // so a flush in this cycle can still leave them untouched.
                state_next = IDLE;
                valid_now  = 1'b1;
                result_now = (cmd_reg == EXE_DIVHI) ? work_hi_reg : work_lo_reg;
                hi_view    = work_hi_reg;
                lo_view    = work_lo_reg;
                hi_next    = work_hi_reg;
                lo_next    = work_lo_reg;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_next = IDLE;
            hi_next    = hi_reg;
            lo_next    = lo_reg;
            valid_now  = 1'b0;
            result_now = 32'd0;
            hi_view    = hi_reg;
            lo_view    = lo_reg;
        end

        if (rst) begin
            stall_now  = 1'b0;
            valid_now  = 1'b0;
            result_now = 32'd0;
            hi_view    = 32'd0;
            lo_view    = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= 5'd0;
            cmd_reg     <= EXE_NOP;
            opnd_reg    <= 32'd0;
            work_hi_reg <= 32'd0;
            work_lo_reg <= 32'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            cmd_reg     <= cmd_next;
            opnd_reg    <= opnd_next;
            work_hi_reg <= work_hi_next;
            work_lo_reg <= work_lo_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign bus.stall        = stall_now;
    assign bus.result_valid = valid_now;
    assign bus.result       = result_now;
    assign bus.hi           = hi_view;
    assign bus.lo           = lo_view;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed scenarios plus random
// operations compared against plain-arithmetic expectations.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one long operation and follow it to completion. With chain set,
    // the next command is held on the bus while the unit is busy.
    task automatic run_op(input exe_cmd_t cmd, input logic [31:0] a, input logic [31:0] b,
                          input bit chain, input exe_cmd_t ncmd,
                          input logic [31:0] na, input logic [31:0] nb);
        logic [63:0] prod;
        logic [31:0] exp_hi, exp_lo, exp_res;
        int exp_lat, lat, stall_cnt;
        if (cmd == EXE_MULT) begin
            prod    = {32'd0, a} * {32'd0, b};
            exp_hi  = prod[63:32];
            exp_lo  = prod[31:0];
            exp_res = exp_lo;
            exp_lat = 33;
        end else begin
            if (b == 32'd0) begin
                exp_lo  = 32'hFFFF_FFFF;
                exp_hi  = a;
                exp_lat = 1;
            end else begin
                exp_lo  = a / b;
                exp_hi  = a % b;
                exp_lat = 33;
            end
            exp_res = (cmd == EXE_DIVHI) ? exp_hi : exp_lo;
        end

        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.exe_cmd   = cmd;
        bus.val1      = a;
        bus.val2      = b;
        @(negedge clk);
        check("accept_stall", bus.stall, 1);
        @(posedge clk); #1;
        if (chain) begin
            bus.exe_cmd = ncmd;
            bus.val1    = na;
            bus.val2    = nb;
        end else begin
            bus.cmd_valid = 1'b0;
            bus.val1      = $urandom;
            bus.val2      = $urandom;
        end
        lat       = 0;
        stall_cnt = 1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.stall === 1'b1) stall_cnt++;
        end
        check("latency", lat, exp_lat);
        check("stall_cycles", stall_cnt, exp_lat);
        check("done_stall", bus.stall, 0);
        check("result", bus.result, exp_res);
        check("hi", bus.hi, exp_hi);
        check("lo", bus.lo, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
        $display("op cmd=%0d a=%h b=%h result=%h hi=%h lo=%h latency=%0d",
                 cmd, a, b, bus.result, bus.hi, bus.lo, lat);
    endtask

    task automatic mf(input exe_cmd_t cmd);
        logic [31:0] exp_res;
        exp_res = (cmd == EXE_MFHI) ? model_hi : model_lo;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.exe_cmd   = cmd;
        @(negedge clk);
        check("mf_valid", bus.result_valid, 1);
        check("mf_stall", bus.stall, 0);
        check("mf_result", bus.result, exp_res);
        $display("mf cmd=%0d result=%h", cmd, bus.result);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("mf_after_valid", bus.result_valid, 0);
        check("mf_after_stall", bus.stall, 0);
    endtask

    initial begin
        bit saw_valid, saw_stall;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.exe_cmd   = EXE_MULT;
        bus.val1      = 32'd7;
        bus.val2      = 32'd6;
        model_hi      = 32'd0;
        model_lo      = 32'd0;

        // Reset: outputs quiet even with a command presented.
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_stall", bus.stall, 0);
        check("rst_valid", bus.result_valid, 0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_hi", bus.hi, 0);
        check("post_rst_lo", bus.lo, 0);
        check("post_rst_result", bus.result, 0);
        check("post_rst_valid", bus.result_valid, 0);
        check("post_rst_stall", bus.stall, 0);
        $display("reset released");

        run_op(EXE_MULT, 32'd7, 32'd6, 1'b0, EXE_NOP, 32'd0, 32'd0);
        run_op(EXE_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, EXE_NOP, 32'd0, 32'd0);
        run_op(EXE_DIVLO, 32'd100, 32'd7, 1'b0, EXE_NOP, 32'd0, 32'd0);
        mf(EXE_MFHI);
        mf(EXE_MFLO);
        run_op(EXE_DIVHI, 32'd5, 32'd0, 1'b0, EXE_NOP, 32'd0, 32'd0);
        mf(EXE_MFLO);

        // Back-to-back: the next command waits on the bus through busy and DONE.
        run_op(EXE_MULT, 32'd1234, 32'd5678, 1'b1, EXE_DIVLO, 32'd1000, 32'd33);
        run_op(EXE_DIVLO, 32'd1000, 32'd33, 1'b0, EXE_NOP, 32'd0, 32'd0);

        // Flush at iteration 10; a MULT offered while busy must be ignored.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.exe_cmd   = EXE_MULT;
        bus.val1      = 32'd3;
        bus.val2      = 32'd3;
        @(negedge clk);
        check("flush_accept_stall", bus.stall, 1);
        @(posedge clk); #1;
        bus.val1 = 32'd9;
        bus.val2 = 32'd9;
        repeat (9) @(posedge clk);
        #1;
        bus.flush     = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("flush_cycle_valid", bus.result_valid, 0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        saw_valid = 1'b0;
        saw_stall = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0) saw_valid = 1'b1;
            if (bus.stall !== 1'b0) saw_stall = 1'b1;
        end
        check("flush_no_valid", saw_valid, 0);
        check("flush_no_stall", saw_stall, 0);
        check("flush_hi", bus.hi, model_hi);
        check("flush_lo", bus.lo, model_lo);
        $display("flush during MULT 3x3 hi=%h lo=%h", bus.hi, bus.lo);

        // Flush wins over acceptance in the same cycle.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.exe_cmd   = EXE_MULT;
        bus.val1      = 32'd5;
        bus.val2      = 32'd5;
        bus.flush     = 1'b1;
        @(negedge clk);
        check("flush_prio_valid", bus.result_valid, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        check("flush_prio_idle", bus.stall, 0);
        $display("flush with simultaneous MULT offer");

        // A command outside the unit's set is ignored.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.exe_cmd   = EXE_ADD;
        @(negedge clk);
        check("ignored_valid", bus.result_valid, 0);
        check("ignored_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("ignored_idle", bus.stall, 0);
        $display("ignored cmd=%0d", EXE_ADD);

        // Reset in the middle of a divide.
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.exe_cmd   = EXE_DIVLO;
        bus.val1      = $urandom;
        bus.val2      = $urandom_range(1, 1000);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", bus.stall, 0);
        check("midrst_valid", bus.result_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_stall", bus.stall, 0);
        check("after_rst_valid", bus.result_valid, 0);
        check("after_rst_result", bus.result, 0);
        check("after_rst_hi", bus.hi, 0);
        check("after_rst_lo", bus.lo, 0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        saw_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b0) saw_valid = 1'b1;
        end
        check("after_rst_no_valid", saw_valid, 0);
        $display("reset during DIV discarded");
        run_op(EXE_DIVLO, 32'd9, 32'd3, 1'b0, EXE_NOP, 32'd0, 32'd0);

        // Random operations.
        for (int i = 0; i < 10; i++) begin
            exe_cmd_t    c;
            logic [31:0] a, b;
            int          sel;
            sel = $urandom_range(0, 2);
            c   = (sel == 0) ? EXE_MULT : ((sel == 1) ? EXE_DIVHI : EXE_DIVLO);
            a   = $urandom;
            sel = $urandom_range(0, 3);
            b   = (sel == 0) ? 32'd0 : ((sel == 1) ? 32'($urandom_range(1, 255)) : 32'($urandom));
            run_op(c, a, b, 1'b0, EXE_NOP, 32'd0, 32'd0);
            mf(($urandom_range(0, 1) == 0) ? EXE_MFHI : EXE_MFLO);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
